// File: rtl/fu_issue_buffer.sv
// fu_issue_buffer: in-order staging FIFO from issue logic to one FU class, registered FU lanes.
// Define FU_ISSUE_BYPASS_EN to forward issued packets straight to free FU lanes while the buffer is empty.
module fu_issue_buffer #(
    parameter int N         = 3,
    parameter int NUM_FU    = 4,
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = 96
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_squash,
    input  logic [N-1:0]                i_in_valid,
    input  logic [N*PAYLOAD_W-1:0]      i_in_payload,
    input  logic [NUM_FU-1:0]           i_fu_avail,
    output logic                        o_space_avail,
    output logic [$clog2(DEPTH+1)-1:0]  o_count,
    output logic [NUM_FU-1:0]           o_fu_valid,
    output logic [NUM_FU*PAYLOAD_W-1:0] o_fu_payload
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    logic [PAYLOAD_W-1:0]        r_mem [DEPTH];
    logic [PW-1:0]               r_head, r_tail;
    logic [CW-1:0]               r_count;
    logic [NUM_FU-1:0]           r_fu_valid;
    logic [NUM_FU*PAYLOAD_W-1:0] r_fu_payload;
    logic [PAYLOAD_W-1:0]        w_cin [N];
    logic [CW-1:0]               w_nin, w_nb, w_k, w_enq;
    logic                        w_byp;
    logic [NUM_FU-1:0]           w_fv;
    logic [NUM_FU*PAYLOAD_W-1:0] w_fp;

    assign o_space_avail = r_count <= CW'(DEPTH - N);
    assign o_count       = r_count;
    assign o_fu_valid    = r_fu_valid;
    assign o_fu_payload  = r_fu_payload;

`ifdef FU_ISSUE_BYPASS_EN
    assign w_byp = (r_count == '0) && !i_squash;
`else
    assign w_byp = 1'b0;
`endif

    always_comb begin : compact
        int n;
        n = 0;
        for (int l = 0; l < N; l++) w_cin[l] = '0;
        for (int l = 0; l < N; l++)
            if (i_in_valid[l]) begin
                w_cin[n] = i_in_payload[l*PAYLOAD_W +: PAYLOAD_W];
                n++;
            end
        w_nin = CW'(n);
    end

    // Oldest source (FIFO head, or compacted issue lanes when bypassing) goes to lowest free FU lane.
    always_comb begin : dispatch
        int j;
        j    = 0;
        w_fv = '0;
        w_fp = r_fu_payload;
        for (int i = 0; i < NUM_FU; i++)
            if (i_fu_avail[i]) begin
                if (w_byp && j < int'(w_nin)) begin
                    w_fv[i] = 1'b1;
                    w_fp[i*PAYLOAD_W +: PAYLOAD_W] = w_cin[j];
                    j++;
                end else if (!w_byp && j < int'(r_count)) begin
                    w_fv[i] = 1'b1;
                    w_fp[i*PAYLOAD_W +: PAYLOAD_W] = r_mem[r_head + PW'(j)];
                    j++;
                end
            end
        w_k   = w_byp ? '0 : CW'(j);
        w_nb  = w_byp ? CW'(j) : '0;
        w_enq = o_space_avail ? w_nin - w_nb : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_fu_valid   <= '0;
            r_fu_payload <= '0;
        end else if (i_squash) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_fu_valid <= '0;
        end else begin
            r_head       <= r_head + PW'(w_k);
            r_tail       <= r_tail + PW'(w_enq);
            r_count      <= r_count + w_enq - w_k;
            r_fu_valid   <= w_fv;
            r_fu_payload <= w_fp;
        end
    end

    // Storage needs no reset: count and pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        for (int e = 0; e < N; e++)
            if (e < int'(w_enq))
                r_mem[r_tail + PW'(e)] <= w_cin[int'(w_nb) + e];
    end
endmodule

// File: tb/tb_fu_issue_buffer.sv
// tb_fu_issue_buffer: scoreboard bench for fu_issue_buffer; stimulus queues expected FU-lane packets,
// a negedge monitor pops and compares them whenever a lane presents fu_valid.
module tb_fu_issue_buffer;
    localparam int N = 3, NUM_FU = 4, DEPTH = 8, PW = 96;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   squash = 1'b0;
    logic [N-1:0]           in_valid = '0;
    logic [N*PW-1:0]        in_payload = '0;
    logic [NUM_FU-1:0]      fu_avail = '0;
    logic                   space_avail;
    logic [3:0]             count;
    logic [NUM_FU-1:0]      fu_valid;
    logic [NUM_FU*PW-1:0]   fu_payload;

    typedef struct {
        int          lane;
        logic [PW-1:0] pl;
    } exp_t;

    exp_t          sb[$];
    logic [PW-1:0] mq[$];
    exp_t          m_e;
    int            checks = 0, errors = 0, mc = 0, seq = 1000;

    fu_issue_buffer #(.N(N), .NUM_FU(NUM_FU), .DEPTH(DEPTH), .PAYLOAD_W(PW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_squash(squash), .i_in_valid(in_valid),
        .i_in_payload(in_payload), .i_fu_avail(fu_avail), .o_space_avail(space_avail),
        .o_count(count), .o_fu_valid(fu_valid), .o_fu_payload(fu_payload)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pk(input int v);
        return {32'hC0DE_0000, 32'(v), 32'(v * 7 + 1)};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic expect_lane(input int lane, input int v);
        exp_t e;
        e.lane = lane;
        e.pl   = pk(v);
        sb.push_back(e);
    endtask

    task automatic drive(input logic [N-1:0] v, input int p0, input int p1, input int p2,
                         input logic [NUM_FU-1:0] av);
        in_valid   = v;
        in_payload = {pk(p2), pk(p1), pk(p0)};
        fu_avail   = av;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = '0;
        fu_avail = '0;
        squash   = 1'b0;
    endtask

    // Reference queue model, used only where av is all-zero or all-one and bypass cannot trigger.
    task automatic wrap_cycle(input bit en, input logic [NUM_FU-1:0] av);
        int   enq, k, na;
        exp_t e;
        enq = (en && mc <= DEPTH - N) ? N : 0;
        na  = $countones(av);
        k   = (na < mc) ? na : mc;
        drive(enq != 0 ? 3'b111 : 3'b000, seq, seq + 1, seq + 2, av);
        for (int i = 0; i < k; i++) begin
            e.lane = i;
            e.pl   = mq.pop_front();
            sb.push_back(e);
        end
        for (int i = 0; i < enq; i++) mq.push_back(pk(seq + i));
        seq += enq;
        mc = mc + enq - k;
        step();
        chk("wrap count", int'(count), mc);
        chk("wrap space_avail", int'(space_avail), mc <= DEPTH - N ? 1 : 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_FU; i++)
                if (fu_valid[i]) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL dispatch: lane %0d got %h with no packet expected", i, fu_payload[i*PW +: PW]);
                    end else begin
                        m_e = sb.pop_front();
                        if (m_e.lane != i || m_e.pl !== fu_payload[i*PW +: PW]) begin
                            errors++;
                            $display("FAIL dispatch: lane %0d payload %h expected lane %0d payload %h",
                                     i, fu_payload[i*PW +: PW], m_e.lane, m_e.pl);
                        end
                    end
                end
            if (!squash && |in_valid && !space_avail) begin
                errors++;
                $display("FAIL issue_protocol: in_valid %b while space_avail=0", in_valid);
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("reset count", int'(count), 0);
        chk("reset space_avail", int'(space_avail), 1);
        chk("reset fu_valid", int'(fu_valid), 0);
        chk("reset fu_payload", int'(|fu_payload), 0);
        step();
        step();
        rst_n = 1'b1;

        // single issue on lane 1
        expect_lane(0, 100);
        drive(3'b010, 0, 100, 0, 4'b1111);
        step();
`ifdef FU_ISSUE_BYPASS_EN
        chk("single count e1", int'(count), 0);
        chk("single fu_valid e1", int'(fu_valid), 'b0001);
`else
        chk("single count e1", int'(count), 1);
        chk("single fu_valid e1", int'(fu_valid), 0);
`endif
        idle();
        fu_avail = 4'b1111;
        step();
`ifdef FU_ISSUE_BYPASS_EN
        chk("single fu_valid e2", int'(fu_valid), 0);
`else
        chk("single fu_valid e2", int'(fu_valid), 'b0001);
`endif
        chk("single count e2", int'(count), 0);
        idle();
        step();
        chk("single drained", sb.size(), 0);

        // partial availability and order
        expect_lane(1, 1);
        expect_lane(3, 2);
        expect_lane(0, 3);
        drive(3'b101, 1, 0, 2, 4'b0000);
        step();
        chk("partial count 1", int'(count), 2);
        drive(3'b010, 0, 3, 0, 4'b0000);
        step();
        chk("partial count 2", int'(count), 3);
        idle();
        fu_avail = 4'b1010;
        step();
        chk("partial count 3", int'(count), 1);
        chk("partial fu_valid 1010", int'(fu_valid), 'b1010);
        fu_avail = 4'b0001;
        step();
        chk("partial count 4", int'(count), 0);
        chk("partial fu_valid 0001", int'(fu_valid), 'b0001);
        idle();
        step();
        chk("partial drained", sb.size(), 0);

        // fill to full, then stream with wrap
        wrap_cycle(1'b1, 4'b0000);
        wrap_cycle(1'b1, 4'b0000);
        for (int c = 0; c < 20; c++) wrap_cycle(1'b1, 4'b1111);
        wrap_cycle(1'b0, 4'b1111);
        wrap_cycle(1'b0, 4'b1111);
        idle();
        step();
        chk("wrap drained", sb.size(), 0);

        // squash with full-ish buffer
        drive(3'b111, 1, 2, 3, 4'b0000);
        step();
        drive(3'b111, 4, 5, 6, 4'b0000);
        step();
        chk("squash pre count", int'(count), 6);
        chk("squash pre space_avail", int'(space_avail), 0);
        drive(3'b111, 7, 8, 9, 4'b1111);
        squash = 1'b1;
        step();
        chk("squash count", int'(count), 0);
        chk("squash fu_valid", int'(fu_valid), 0);
        chk("squash space_avail", int'(space_avail), 1);
        idle();
        fu_avail = 4'b1111;
        step();
        chk("post squash fu_valid", int'(fu_valid), 0);
        chk("post squash count", int'(count), 0);

        // bypass candidate: empty buffer, three issued, two free slots
        idle();
        expect_lane(1, 200);
        expect_lane(2, 201);
        expect_lane(0, 202);
        drive(3'b111, 200, 201, 202, 4'b0110);
        step();
`ifdef FU_ISSUE_BYPASS_EN
        chk("bypass count e1", int'(count), 1);
        chk("bypass fu_valid e1", int'(fu_valid), 'b0110);
        idle();
        fu_avail = 4'b0001;
        step();
`else
        chk("bypass count e1", int'(count), 3);
        chk("bypass fu_valid e1", int'(fu_valid), 0);
        idle();
        fu_avail = 4'b0110;
        step();
        chk("bypass count e2", int'(count), 1);
        fu_avail = 4'b0001;
        step();
`endif
        chk("bypass count end", int'(count), 0);
        chk("bypass fu_valid end", int'(fu_valid), 'b0001);
        idle();
        step();
        chk("bypass drained", sb.size(), 0);

        // asynchronous reset mid-traffic
        expect_lane(0, 300);
        drive(3'b111, 300, 301, 302, 4'b0000);
        step();
        chk("rst pre count 1", int'(count), 3);
        drive(3'b111, 303, 304, 305, 4'b0001);
        step();
        chk("rst pre count 2", int'(count), 5);
        chk("rst pre fu_valid", int'(fu_valid), 'b0001);
        idle();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst count", int'(count), 0);
        chk("async rst fu_valid", int'(fu_valid), 0);
        chk("async rst space_avail", int'(space_avail), 1);
        chk("async rst fu_payload", int'(|fu_payload), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("post rst fu_valid", int'(fu_valid), 0);
        chk("post rst count", int'(count), 0);
        chk("post rst fu_payload", int'(|fu_payload), 0);
        chk("final drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
